mod_sched: RTL and testbench
============================

MOD_SCHED -- requirements
Module: mod_sched

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  input  32 each  requester 0 dividend and divisor (unsigned).
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  SHALL be as REQ-004 to REQ-006, for requester 1.
REQ-008 res_valid  output  1  one-cycle pulse; result fields valid.
REQ-009 res_id  output  1  requester index that owns the result.
REQ-010 res_value  output  32  A mod B.
REQ-011 res_dz  output  1  divide-by-zero flag for this result.
REQ-012 busy  output  1  high while an operation is in progress (ITER or DONE).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ITER, DONE.
REQ-014 reqN_ready SHALL be combinational, high only in IDLE, with reset deasserted, reqN_valid high and requester N granted.
- At most one ready per cycle.
REQ-015 Acceptance SHALL occur on the edge where valid and ready are both high.
- Capture a, b and id; rem <= a; IDLE -> ITER.
REQ-016 ITER, b==0: -> DONE; res_value <= a, res_dz <= 1.
REQ-017 ITER, rem < b: -> DONE; res_value <= rem, res_dz <= 0.
REQ-018 ITER, otherwise: rem <= rem - b (32-bit unsigned, no wrap possible); stay in ITER.
REQ-019 DONE SHALL assert res_valid for exactly one cycle, then -> IDLE; no result backpressure.
REQ-020 res_valid SHALL rise q+1 edges after the acceptance edge, where q = floor(a/b).
- For b==0, q is taken as 0.
REQ-021 A new request SHALL NOT be accepted before the cycle after res_valid.
- Minimum acceptance spacing = q+3 cycles.
REQ-022 res_value, res_id and res_dz SHALL hold their last values until the next DONE.
REQ-023 Requests arriving while busy SHALL be held by the requester (valid stays high) and never dropped.
REQ-024 Operand changes while valid is high and ready is low SHALL have no effect; only values present at the acceptance edge are used.

Reset
REQ-025 With reset low at an edge, the block SHALL set state=IDLE, res_valid=0, res_id=0, res_value=0, res_dz=0, busy=0, rem=0, and the priority pointer to requester 0.
REQ-026 While reset is low, both readies SHALL be 0.
REQ-027 Reset during ITER or DONE SHALL abandon the operation with no res_valid pulse.

Configuration
REQ-028 Macro MOD_SCHED_RR_EN SHALL select the arbitration policy.
REQ-029 Defined: round-robin arbitration.
- If both requesters are valid, the pointer requester wins.
- After every acceptance, the pointer moves to the other requester.
- If only one requester is valid, it wins regardless of the pointer.
REQ-030 Undefined: fixed priority; requester 0 always wins when valid. The pointer logic is absent.

Verification
REQ-031 Single operation: req0 a=35, b=15 accepted at edge E0 -> res_valid at E3, res_value=5, res_id=0, res_dz=0.
REQ-032 Long operation: req1 a=100, b=7 -> res_value=2, res_id=1, res_valid 15 edges after acceptance, busy high throughout.
REQ-033 Boundaries:
- a=9, b=0 -> res_value=9, res_dz=1 after 1 edge.
- a=3, b=8 -> res_value=3 after 1 edge.
- a=0, b=5 -> res_value=0.
REQ-034 Contention: both valid continuously, ops (35,15) and (20,6).
- RR_EN defined: grants alternate 0,1,0,1.
- RR_EN undefined: only requester 0 is granted.
REQ-035 Reset mid-operation: accept a=1000, b=1; assert reset after 5 cycles -> no res_valid, all outputs zero, next request accepted normally.

Source files
------------

// File: rtl/mod_sched_if.sv
// Request/result bundle for mod_sched: two operand requesters plus the shared result port.
// The master side drives requests; the slave side (the scheduler) accepts and returns results.
interface mod_sched_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic        res_valid;
    logic        res_id;
    logic [31:0] res_value;
    logic        res_dz;
    logic        busy;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  req0_ready, req1_ready, res_valid, res_id, res_value, res_dz, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output req0_ready, req1_ready, res_valid, res_id, res_value, res_dz, busy
    );
endinterface

// File: rtl/mod_sched.sv
// mod_sched: two-requester unsigned A mod B by repeated subtraction, one operation at a time.
// Define MOD_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
//   state | meaning
//   IDLE  | waiting for a request; the granted requester sees ready
//   ITER  | subtracting b from rem until rem < b (or b == 0)
//   DONE  | res_valid pulse cycle, back to IDLE next edge
module mod_sched (
    input  logic       clk,
    input  logic       reset,
    mod_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] rem_q;
    logic [31:0] rem_d;
    logic        id_q;
    logic        res_valid_q;
    logic        res_id_q;
    logic [31:0] res_value_q;
    logic        res_dz_q;

    logic        gnt0;
    logic        gnt1;
    logic        ready0;
    logic        ready1;
    logic        accept;
    logic        win_id;
    logic [31:0] acc_a;
    logic [31:0] acc_b;

`ifdef MOD_SCHED_RR_EN
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || !ptr_q);
        gnt1 = bus.req1_valid && (!bus.req0_valid || ptr_q);
    end

    // Pointer goes to the requester that just lost its turn.
    assign ptr_d = ~win_id;
`else
    always_comb begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid && !bus.req0_valid;
    end
`endif

    assign ready0 = reset && (state_q == IDLE) && gnt0;
    assign ready1 = reset && (state_q == IDLE) && gnt1;
    assign accept = ready0 || ready1;
    assign win_id = ready1;
    assign acc_a  = win_id ? bus.req1_a : bus.req0_a;
    assign acc_b  = win_id ? bus.req1_b : bus.req0_b;
    assign rem_d  = rem_q - b_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_value_q <= '0;
            res_dz_q    <= 1'b0;
`ifdef MOD_SCHED_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= acc_a;
                        b_q     <= acc_b;
                        rem_q   <= acc_a;
                        id_q    <= win_id;
                        state_q <= ITER;
`ifdef MOD_SCHED_RR_EN
                        ptr_q   <= ptr_d;
`endif
                    end
                end
                ITER: begin
                    if (b_q == '0) begin
                        res_value_q <= a_q;
                        res_dz_q    <= 1'b1;
                        res_id_q    <= id_q;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (rem_q < b_q) begin
                        res_value_q <= rem_q;
                        res_dz_q    <= 1'b0;
                        res_id_q    <= id_q;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rem_q <= rem_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_value  = res_value_q;
    assign bus.res_dz     = res_dz_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mod_sched.sv
// Testbench for mod_sched: directed and randomized operations checked against an arithmetic model
// (result = a % b, or a with dz when b == 0; latency = floor(a/b) + 1 edges).
module tb_mod_sched;
    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    mod_sched_if sif ();

    mod_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_val(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? a : (a % b);
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? 1 : int'(a / b) + 1;
    endfunction

    task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            sif.req0_valid = v; sif.req0_a = a; sif.req0_b = b;
        end else begin
            sif.req1_valid = v; sif.req1_a = a; sif.req1_b = b;
        end
    endtask

    // Driver only: presents one request, waits for acceptance and result; called just after a negedge.
    task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                          output bit acc_ok, output bit res_ok, output int lat,
                          output logic [31:0] val, output logic id, output logic dz,
                          output bit pulse_ok, output bit busy_ok);
        int acc;
        acc = 0; acc_ok = 0; res_ok = 0; lat = -1; val = '0; id = 1'b0; dz = 1'b0;
        pulse_ok = 0; busy_ok = 1;
        set_req(r, 1'b1, a, b);
        for (int i = 0; i < 50 && !acc_ok; i++) begin
            #1;
            if ((r == 0) ? sif.req0_ready : sif.req1_ready) begin
                @(posedge clk); #1;
                acc = cyc;
                acc_ok = 1;
            end
            @(negedge clk);
        end
        set_req(r, 1'b0, $urandom, $urandom);
        if (!acc_ok) return;
        for (int i = 0; i < 4000; i++) begin
            if (!sif.busy) busy_ok = 0;
            if (sif.res_valid) begin
                lat = cyc - acc; val = sif.res_value; id = sif.res_id; dz = sif.res_dz;
                res_ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!res_ok) return;
        @(negedge clk);
        pulse_ok = !sif.res_valid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        sif.req0_valid = 1'b1; sif.req1_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        total += 7;
        if (sif.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b want 0", sif.req0_ready); end
        if (sif.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %b want 0", sif.req1_ready); end
        if (sif.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", sif.res_valid); end
        if (sif.res_id !== 1'b0) begin bad++; $display("FAIL reset_res_id: got %b want 0", sif.res_id); end
        if (sif.res_value !== 32'd0) begin bad++; $display("FAIL reset_res_value: got %0d want 0", sif.res_value); end
        if (sif.res_dz !== 1'b0) begin bad++; $display("FAIL reset_res_dz: got %b want 0", sif.res_dz); end
        if (sif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", sif.busy); end
        sif.req0_valid = 1'b0; sif.req1_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (sif.req0_ready !== 1'b0 || sif.req1_ready !== 1'b0) begin
            bad++; $display("FAIL idle_ready_no_valid: got %b%b want 00", sif.req0_ready, sif.req1_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        bit acc_ok, res_ok, pulse_ok, busy_ok;
        int lat;
        logic [31:0] val;
        logic id, dz;
        run_op(0, 32'd35, 32'd15, acc_ok, res_ok, lat, val, id, dz, pulse_ok, busy_ok);
        total += 6;
        if (!acc_ok || !res_ok) begin bad++; $display("FAIL single_handshake: acc=%0d res=%0d want 1 1", acc_ok, res_ok); end
        if (val !== 32'd5) begin bad++; $display("FAIL single_value: got %0d want 5", val); end
        if (id !== 1'b0 || dz !== 1'b0) begin bad++; $display("FAIL single_id_dz: got %b %b want 0 0", id, dz); end
        if (lat != 3) begin bad++; $display("FAIL single_latency: got %0d want 3", lat); end
        if (!pulse_ok) begin bad++; $display("FAIL single_pulse_width: got >1 cycle want 1"); end
        repeat (3) @(negedge clk);
        if (sif.res_value !== 32'd5 || sif.busy !== 1'b0) begin
            bad++; $display("FAIL single_hold: got value=%0d busy=%b want 5 0", sif.res_value, sif.busy);
        end
    endtask

    task automatic test_long();
        bit acc_ok, res_ok, pulse_ok, busy_ok;
        int lat;
        logic [31:0] val;
        logic id, dz;
        run_op(1, 32'd100, 32'd7, acc_ok, res_ok, lat, val, id, dz, pulse_ok, busy_ok);
        total += 5;
        if (!acc_ok || !res_ok) begin bad++; $display("FAIL long_handshake: acc=%0d res=%0d want 1 1", acc_ok, res_ok); end
        if (val !== 32'd2 || dz !== 1'b0) begin bad++; $display("FAIL long_value: got %0d dz=%b want 2 0", val, dz); end
        if (id !== 1'b1) begin bad++; $display("FAIL long_id: got %b want 1", id); end
        if (lat != 15) begin bad++; $display("FAIL long_latency: got %0d want 15", lat); end
        if (!busy_ok) begin bad++; $display("FAIL long_busy: got busy low during op want high"); end
    endtask

    task automatic test_boundaries();
        logic [31:0] ta [5] = '{32'd9, 32'd3, 32'd0, 32'd15, 32'hFFFF_FFFF};
        logic [31:0] tb [5] = '{32'd0, 32'd8, 32'd5, 32'd15, 32'h8000_0000};
        bit acc_ok, res_ok, pulse_ok, busy_ok;
        int lat;
        logic [31:0] val;
        logic id, dz;
        for (int k = 0; k < 5; k++) begin
            run_op(k % 2, ta[k], tb[k], acc_ok, res_ok, lat, val, id, dz, pulse_ok, busy_ok);
            total += 3;
            if (!acc_ok || !res_ok || !pulse_ok) begin
                bad++; $display("FAIL bound%0d_handshake: acc=%0d res=%0d pulse=%0d want 1 1 1", k, acc_ok, res_ok, pulse_ok);
            end
            if (val !== ref_val(ta[k], tb[k]) || dz !== (tb[k] == 0) || id !== 1'(k % 2)) begin
                bad++; $display("FAIL bound%0d_result: got %0d dz=%b id=%b want %0d dz=%b id=%0d",
                                k, val, dz, id, ref_val(ta[k], tb[k]), (tb[k] == 0), k % 2);
            end
            if (lat != ref_lat(ta[k], tb[k])) begin
                bad++; $display("FAIL bound%0d_latency: got %0d want %0d", k, lat, ref_lat(ta[k], tb[k]));
            end
        end
    endtask

    task automatic test_random();
        bit acc_ok, res_ok, pulse_ok, busy_ok;
        int lat, r, mode;
        logic [31:0] a, b, val;
        logic id, dz;
        for (int k = 0; k < 16; k++) begin
            r = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin a = $urandom; b = 32'd0; end
            else if (mode == 1) begin a = $urandom; b = $urandom | 32'h4000_0000; end
            else begin a = $urandom_range(0, 600); b = $urandom_range(1, 60); end
            run_op(r, a, b, acc_ok, res_ok, lat, val, id, dz, pulse_ok, busy_ok);
            total++;
            if (!acc_ok || !res_ok || !pulse_ok || !busy_ok || val !== ref_val(a, b) ||
                dz !== (b == 0) || id !== 1'(r) || lat != ref_lat(a, b)) begin
                bad++;
                $display("FAIL rand%0d a=%0d b=%0d r=%0d: got val=%0d dz=%b id=%b lat=%0d hs=%0d%0d%0d%0d want val=%0d dz=%b lat=%0d hs=1111",
                         k, a, b, r, val, dz, id, lat, acc_ok, res_ok, pulse_ok, busy_ok,
                         ref_val(a, b), (b == 0), ref_lat(a, b));
            end
        end
    endtask

    // Requester 0 waits behind a requester 1 op with its operands churning; only acceptance-edge values count.
    task automatic test_back_to_back();
        logic [31:0] ha, hb;
        int acc0, acc1;
        bit got, seen;
        ha = 0; hb = 1; acc0 = 0; acc1 = 0; got = 0; seen = 0;
        set_req(1, 1'b1, 32'd100, 32'd7);
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (sif.req1_ready) begin @(posedge clk); #1; acc1 = cyc; got = 1; end
            @(negedge clk);
        end
        set_req(1, 1'b0, 32'd0, 32'd0);
        total++;
        if (!got) begin bad++; $display("FAIL b2b_first_accept: got none want accept"); end
        got = 0;
        sif.req0_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            ha = $urandom_range(0, 300); hb = $urandom_range(1, 20);
            sif.req0_a = ha; sif.req0_b = hb;
            #1;
            if (sif.res_valid) begin
                seen = 1;
                total++;
                if (sif.res_value !== 32'd2 || sif.res_id !== 1'b1) begin
                    bad++; $display("FAIL b2b_first_result: got %0d id=%b want 2 id=1", sif.res_value, sif.res_id);
                end
            end
            if (sif.req0_ready) begin @(posedge clk); #1; acc0 = cyc; got = 1; end
            @(negedge clk);
        end
        sif.req0_valid = 1'b0;
        total += 2;
        if (!got || !seen) begin bad++; $display("FAIL b2b_second_accept: accept=%0d seen_first=%0d want 1 1", got, seen); end
        if (acc0 - acc1 != 17) begin bad++; $display("FAIL b2b_spacing: got %0d want 17", acc0 - acc1); end
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            sif.req0_a = $urandom; sif.req0_b = $urandom;
            if (sif.res_valid) begin
                got = 1;
                total += 2;
                if (sif.res_value !== ref_val(ha, hb) || sif.res_id !== 1'b0 || sif.res_dz !== 1'b0) begin
                    bad++; $display("FAIL b2b_held_result: got %0d id=%b want %0d id=0 (a=%0d b=%0d)",
                                    sif.res_value, sif.res_id, ref_val(ha, hb), ha, hb);
                end
                if (cyc - acc0 != ref_lat(ha, hb)) begin
                    bad++; $display("FAIL b2b_held_latency: got %0d want %0d", cyc - acc0, ref_lat(ha, hb));
                end
            end
            @(negedge clk);
        end
        total++;
        if (!got) begin bad++; $display("FAIL b2b_held_timeout: got no result want one"); end
    endtask

    task automatic test_contention();
        int grants [4];
        int ng, nres, last_g, exp_g;
        logic [31:0] exp_v;
        ng = 0; nres = 0; last_g = 0;
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        set_req(0, 1'b1, 32'd35, 32'd15);
        set_req(1, 1'b1, 32'd20, 32'd6);
        for (int i = 0; i < 200 && nres < 4; i++) begin
            #1;
            if (sif.req0_ready && sif.req1_ready) begin
                bad++; total++; $display("FAIL cont_two_ready: got 11 want at most one");
            end
            if (sif.res_valid) begin
                nres++;
                exp_v = (last_g == 0) ? 32'd5 : 32'd2;
                total++;
                if (sif.res_value !== exp_v || sif.res_id !== 1'(last_g)) begin
                    bad++; $display("FAIL cont_result%0d: got %0d id=%b want %0d id=%0d", nres, sif.res_value, sif.res_id, exp_v, last_g);
                end
            end
            if (ng < 4 && sif.req0_ready) begin grants[ng] = 0; last_g = 0; ng++; end
            else if (ng < 4 && sif.req1_ready) begin grants[ng] = 1; last_g = 1; ng++; end
            if (nres < 4) @(negedge clk);
        end
        sif.req0_valid = 1'b0; sif.req1_valid = 1'b0;
        total++;
        if (ng != 4 || nres != 4) begin bad++; $display("FAIL cont_count: got grants=%0d results=%0d want 4 4", ng, nres); end
        for (int k = 0; k < ng; k++) begin
`ifdef MOD_SCHED_RR_EN
            exp_g = k % 2;
`else
            exp_g = 0;
`endif
            total++;
            if (grants[k] != exp_g) begin bad++; $display("FAIL cont_grant%0d: got %0d want %0d", k, grants[k], exp_g); end
        end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got, pulsed, acc_ok, res_ok, pulse_ok, busy_ok;
        int lat;
        logic [31:0] val;
        logic id, dz;
        got = 0; pulsed = 0;
        set_req(0, 1'b1, 32'd1000, 32'd1);
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (sif.req0_ready) begin @(posedge clk); got = 1; end
            @(negedge clk);
        end
        set_req(0, 1'b0, 32'd0, 32'd0);
        repeat (5) begin @(negedge clk); if (sif.res_valid) pulsed = 1; end
        reset = 1'b0;
        sif.req0_valid = 1'b1; sif.req1_valid = 1'b1;
        #1;
        total++;
        if (sif.req0_ready !== 1'b0 || sif.req1_ready !== 1'b0) begin
            bad++; $display("FAIL mid_ready_in_reset: got %b%b want 00", sif.req0_ready, sif.req1_ready);
        end
        @(negedge clk);
        total += 2;
        if (!got || sif.busy !== 1'b0 || sif.res_valid !== 1'b0) begin
            bad++; $display("FAIL mid_state: accepted=%0d busy=%b res_valid=%b want 1 0 0", got, sif.busy, sif.res_valid);
        end
        if (sif.res_value !== 32'd0 || sif.res_id !== 1'b0 || sif.res_dz !== 1'b0) begin
            bad++; $display("FAIL mid_outputs: got %0d id=%b dz=%b want 0 0 0", sif.res_value, sif.res_id, sif.res_dz);
        end
        sif.req0_valid = 1'b0; sif.req1_valid = 1'b0;
        reset = 1'b1;
        repeat (30) begin @(negedge clk); if (sif.res_valid || sif.busy) pulsed = 1; end
        total++;
        if (pulsed) begin bad++; $display("FAIL mid_no_pulse: got activity after abandon want none"); end
        run_op(1, 32'd77, 32'd10, acc_ok, res_ok, lat, val, id, dz, pulse_ok, busy_ok);
        total++;
        if (!acc_ok || !res_ok || val !== 32'd7 || id !== 1'b1 || lat != 8) begin
            bad++; $display("FAIL mid_next_op: got acc=%0d res=%0d val=%0d id=%b lat=%0d want 1 1 7 1 8",
                            acc_ok, res_ok, val, id, lat);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0;
        sif.req0_valid = 1'b0; sif.req0_a = '0; sif.req0_b = '0;
        sif.req1_valid = 1'b0; sif.req1_a = '0; sif.req1_b = '0;
        test_reset();
        test_single();
        test_long();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_contention();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
